// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency instruction ROM
// and buffers responses in a 2-entry queue. Optional counters: FETCH_PERF_COUNTERS_EN.
module fetch_unit #(
  parameter int                      PC_WIDTH    = 16,
  parameter int                      INSTR_WIDTH = 20,
  parameter int                      PC_STEP     = 1,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   select_pc_mux,
  input  logic [PC_WIDTH-1:0]    branch_address,
  output logic [PC_WIDTH-1:0]    imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instruction_fetch,
  output logic [PC_WIDTH-1:0]    pc_mux_output,
  output logic                   fetch_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [15:0]            redirect_count,
  output logic [15:0]            stall_count
`endif
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                   epoch_q, epoch_d;
  logic                   infl_valid_q, infl_valid_d;
  logic [PC_WIDTH-1:0]    infl_pc_q, infl_pc_d;
  logic                   infl_epoch_q, infl_epoch_d;
  logic [1:0]             occ_q, occ_d;
  logic [PC_WIDTH-1:0]    last_pc_q, last_pc_d;
  logic [PC_WIDTH-1:0]    buf_pc_q    [2];
  logic [PC_WIDTH-1:0]    buf_pc_d    [2];
  logic [INSTR_WIDTH-1:0] buf_instr_q [2];
  logic [INSTR_WIDTH-1:0] buf_instr_d [2];

  logic       redirect;
  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ_after;
  logic [1:0] wr_idx;

  assign imem_address      = fetch_pc_q;
  assign fetch_valid       = (occ_q != 2'd0);
  assign instruction_fetch = fetch_valid ? buf_instr_q[0] : NOP_INSTR;
  assign pc_mux_output     = fetch_valid ? buf_pc_q[0] : last_pc_q;

  // A redirect discards everything, so it suppresses consume, completion and issue alike.
  assign redirect  = flush | select_pc_mux;
  assign pop       = fetch_valid & ~stall & ~redirect;
  assign push      = infl_valid_q & (infl_epoch_q == epoch_q) & ~redirect;
  assign occ_after = occ_q - {1'b0, pop} + {1'b0, push};
  assign wr_idx    = occ_q - {1'b0, pop};
  assign issue     = ~redirect & (occ_after < 2'd2);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    epoch_d      = epoch_q;
    infl_valid_d = issue;
    infl_pc_d    = fetch_pc_q;
    infl_epoch_d = epoch_q;
    occ_d        = occ_q;
    last_pc_d    = pc_mux_output;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;

    if (redirect) begin
      occ_d      = 2'd0;
      epoch_d    = ~epoch_q;
      fetch_pc_d = select_pc_mux ? branch_address : (pc_mux_output + STEP);
    end else begin
      if (pop) begin
        buf_pc_d[0]    = buf_pc_q[1];
        buf_instr_d[0] = buf_instr_q[1];
      end
      // Write after the shift so a same-cycle pop+push lands in the freed slot.
      if (push && (wr_idx < 2'd2)) begin
        buf_pc_d[wr_idx[0]]    = infl_pc_q;
        buf_instr_d[wr_idx[0]] = imem_data;
      end
      occ_d = occ_after;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      epoch_q      <= 1'b0;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= '0;
      infl_epoch_q <= 1'b0;
      occ_q        <= 2'd0;
      last_pc_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= NOP_INSTR;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
      infl_epoch_q <= infl_epoch_d;
      occ_q        <= occ_d;
      last_pc_q    <= last_pc_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] redirect_count_q, redirect_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    redirect_count_d = redirect_count_q;
    stall_count_d    = stall_count_q;
    if (redirect && (redirect_count_q != 16'hFFFF)) begin
      redirect_count_d = redirect_count_q + 16'd1;
    end
    if (stall && fetch_valid && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      redirect_count_q <= 16'd0;
      stall_count_q    <= 16'd0;
    end else begin
      redirect_count_q <= redirect_count_d;
      stall_count_q    <= stall_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign stall_count    = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected PCs plus point checks.
module tb_fetch_unit;

  logic        clk;
  logic        reset, stall, flush, select_pc_mux;
  logic [15:0] branch_address;
  logic [15:0] imem_address;
  logic [19:0] imem_data;
  logic [19:0] instruction_fetch;
  logic [15:0] pc_mux_output;
  logic        fetch_valid;

  logic        reset2;
  logic [15:0] imem_address2;
  logic [19:0] imem_data2;
  logic [19:0] instruction_fetch2;
  logic [15:0] pc_mux_output2;
  logic        fetch_valid2;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] redirect_count, stall_count;
  logic [15:0] redirect_count2, stall_count2;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];

  fetch_unit dut_main (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .select_pc_mux(select_pc_mux), .branch_address(branch_address),
    .imem_address(imem_address), .imem_data(imem_data),
    .instruction_fetch(instruction_fetch), .pc_mux_output(pc_mux_output),
    .fetch_valid(fetch_valid)
`ifdef FETCH_PERF_COUNTERS_EN
    , .redirect_count(redirect_count), .stall_count(stall_count)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset2), .stall(1'b0), .flush(1'b0),
    .select_pc_mux(1'b0), .branch_address(16'h0000),
    .imem_address(imem_address2), .imem_data(imem_data2),
    .instruction_fetch(instruction_fetch2), .pc_mux_output(pc_mux_output2),
    .fetch_valid(fetch_valid2)
`ifdef FETCH_PERF_COUNTERS_EN
    , .redirect_count(redirect_count2), .stall_count(stall_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM models: mem[a] = {4'h0, a}
  always @(posedge clk) begin
    imem_data  <= {4'h0, imem_address};
    imem_data2 <= {4'h0, imem_address2};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_head(input logic [15:0] target, input string tag);
    int n;
    n = 0;
    while (!(fetch_valid && pc_mux_output == target) && n < 40) begin
      step();
      n++;
    end
    check(tag, {15'h0, fetch_valid, pc_mux_output}, {15'h0, 1'b1, target});
  endtask

  // Consumption monitor: an instruction is taken at an edge with valid, no stall, no redirect.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset && fetch_valid && !stall && !flush && !select_pc_mux) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed pc %0h expected none", pc_mux_output);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("consume pc=%04h instr=%05h", pc_mux_output, instruction_fetch);
        check("sb_pc", 32'(pc_mux_output), 32'(e));
        check("sb_instr", 32'(instruction_fetch), {12'h0, 4'h0, e});
      end
    end
    if (reset2 && fetch_valid2 && exp2_q.size() != 0) begin
      e = exp2_q.pop_front();
      $display("consume wrap pc=%04h instr=%05h", pc_mux_output2, instruction_fetch2);
      check("sb2_pc", 32'(pc_mux_output2), 32'(e));
      check("sb2_instr", 32'(instruction_fetch2), {12'h0, 4'h0, e});
    end
    checks++;
    assert (dut_main.occ_q <= 2'd2) else begin
      errors++;
      $error("FAIL occ_overflow: observed %0d expected <= 2", dut_main.occ_q);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; reset2 = 1'b0; stall = 1'b0; flush = 1'b0;
    select_pc_mux = 1'b0; branch_address = 16'h0000;
    repeat (3) step();
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_instr", 32'(instruction_fetch), 32'd0);
    check("rst_pc", 32'(pc_mux_output), 32'd0);
    check("rst_addr", 32'(imem_address), 32'h0000);
    check("rst_addr2", 32'(imem_address2), 32'hFFFE);
    check("rst_valid2", 32'(fetch_valid2), 32'd0);

    for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
    exp2_q.push_back(16'hFFFE); exp2_q.push_back(16'hFFFF);
    exp2_q.push_back(16'h0000); exp2_q.push_back(16'h0001);
    reset = 1'b1; reset2 = 1'b1;
    step();
    check("e1_valid", 32'(fetch_valid), 32'd0);
    step();
    check("e2_valid", 32'(fetch_valid), 32'd1);
    check("e2_instr", 32'(instruction_fetch), 32'h00000);
    wait_head(16'h0003, "head3");

    // Stall with head at pc 3
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_instr", 32'(instruction_fetch), 32'h00003);
      check("stall_valid", 32'(fetch_valid), 32'd1);
    end
    for (int i = 3; i < 7; i++) exp_q.push_back(16'(i));
    stall = 1'b0;
    wait_head(16'h0007, "head7");

    // Branch to 0x40 while head is pc 7
    exp_q.push_back(16'h0040); exp_q.push_back(16'h0041);
    select_pc_mux = 1'b1; branch_address = 16'h0040;
    step();
    select_pc_mux = 1'b0;
    check("br_b1_valid", 32'(fetch_valid), 32'd0);
    check("br_b1_instr", 32'(instruction_fetch), 32'h00000);
    check("br_addr", 32'(imem_address), 32'h0040);
    step();
    check("br_b2_valid", 32'(fetch_valid), 32'd0);
    check("br_b2_instr", 32'(instruction_fetch), 32'h00000);
    step();
    check("br_first_valid", 32'(fetch_valid), 32'd1);
    check("br_first_instr", 32'(instruction_fetch), 32'h00040);
    wait_head(16'h0042, "head42");

    // Stall and branch in the same cycle: redirect wins
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0011);
    stall = 1'b1; select_pc_mux = 1'b1; branch_address = 16'h0010;
    step();
    stall = 1'b0; select_pc_mux = 1'b0;
    check("sb_br_b1_valid", 32'(fetch_valid), 32'd0);
    step();
    check("sb_br_b2_valid", 32'(fetch_valid), 32'd0);
    step();
    check("sb_br_first_valid", 32'(fetch_valid), 32'd1);
    check("sb_br_first_instr", 32'(instruction_fetch), 32'h00010);
    wait_head(16'h0012, "head12");

    // Fill the buffer under stall, then reset for one cycle
    stall = 1'b1;
    repeat (3) step();
    check("occ_full", 32'(dut_main.occ_q), 32'd2);
    check("full_instr", 32'(instruction_fetch), 32'h00012);
`ifdef FETCH_PERF_COUNTERS_EN
    check("redirect_count", 32'(redirect_count), 32'd2);
    check("stall_count", 32'(stall_count), 32'd9);
`endif
    reset = 1'b0;
    step();
    check("mid_rst_valid", 32'(fetch_valid), 32'd0);
    check("mid_rst_instr", 32'(instruction_fetch), 32'h00000);
    check("mid_rst_pc", 32'(pc_mux_output), 32'h0000);
`ifdef FETCH_PERF_COUNTERS_EN
    check("rst_redirect_count", 32'(redirect_count), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
    reset = 1'b1; stall = 1'b0;
    wait_head(16'h0003, "head3_again");

    // Plain flush restarts right after the head
    exp_q.push_back(16'h0004); exp_q.push_back(16'h0005);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(fetch_valid), 32'd0);
    check("flush_addr", 32'(imem_address), 32'h0004);
    wait_head(16'h0006, "head6_after_flush");

    stall = 1'b1;
    step();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    check("sb2_drain", 32'(exp2_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the pipeline's instruction stream: `instruction_fetch` and `pc_mux_output` feeding FetchDecode_register.
- Owns the fetch PC and drives a synchronous instruction ROM with 1-cycle read latency.
- A 2-entry buffer absorbs the in-flight ROM response while stalled.
- Follows the hazard unit's stall and flush and the comparator's branch redirect (`select_pc_mux`, `branch_address`).

Parameters:
- PC_WIDTH, 16, width of PC and ROM address.
- INSTR_WIDTH, 20, instruction width.
- PC_STEP, 1, PC increment per sequential instruction.
- RESET_PC, 0, first fetch address after reset.
- NOP_INSTR, 0, value driven on instruction_fetch when not valid.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- stall  in  1  hazard-unit NOP request; hold current output
- flush  in  1  discard all fetched and in-flight instructions
- select_pc_mux  in  1  branch taken in decode
- branch_address  in  PC_WIDTH  redirect target
- imem_address  out  PC_WIDTH  ROM address; sampled by ROM at clk edge
- imem_data  in  INSTR_WIDTH  ROM data for the address sampled at the previous edge
- instruction_fetch  out  INSTR_WIDTH  instruction to FetchDecode_register
- pc_mux_output  out  PC_WIDTH  PC of instruction_fetch
- fetch_valid  out  1  instruction_fetch holds a real instruction

Behaviour:
- Reset (reset==0 at posedge) has priority over all else:
  - fetch_pc = RESET_PC, buffer emptied, in-flight flag cleared, epoch = 0.
  - instruction_fetch = NOP_INSTR, pc_mux_output = 0, fetch_valid = 0.
  - imem_address = RESET_PC.
- imem_address is driven combinationally from the fetch_pc register.
- Request/response tracking:
  - A request is "issued" at an edge where fetch_pc advances; tag {pc, epoch} is recorded in a 1-deep in-flight register.
  - The response is written into the buffer at the following edge if its tag epoch equals the current epoch; otherwise it is dropped.
- Buffer:
  - 2 entries {pc, instr}; the head drives instruction_fetch, pc_mux_output and fetch_valid = (occupancy > 0).
  - Empty buffer: outputs are NOP_INSTR, last PC and valid 0.
- Consume: at an edge with fetch_valid & ~stall, the head is popped.
- Issue rule: issue at an edge when (occupancy after pop) + (in-flight after completion) < 2. Then fetch_pc += PC_STEP, modulo 2^PC_WIDTH (0xFFFF wraps to 0x0000).
- Steady state without stall: 1 instruction per cycle, consecutive PCs.
- Stall:
  - Outputs hold.
  - At most one further response lands in buffer entry 1.
  - fetch_pc freezes once occupancy + in-flight = 2.
  - No instruction is lost or duplicated across any stall length.
- Redirect (flush | select_pc_mux sampled at edge E):
  - Buffer cleared, epoch toggled, fetch_pc = branch_address.
  - When flush=1 without select_pc_mux, fetch_pc = current pc_mux_output + PC_STEP (restart after the head).
  - After E, fetch_valid = 0. The first target instruction is visible after edge E+2 (2 bubbles).
  - A stale in-flight response is dropped.
  - Redirect beats stall and consume in the same cycle.
- Simultaneous pop and push keeps occupancy constant.
- Occupancy never exceeds 2; an overflow is a design error, flagged by a bench assertion.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined: adds output ports redirect_count[15:0] and stall_count[15:0].
  - Both are saturating at 0xFFFF and cleared by reset.
  - redirect_count increments per redirect edge.
  - stall_count increments per edge with stall & fetch_valid.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Bench ROM model: registered, mem[a] = {4'h0, a}.
- Reset then run 6 cycles with no stall -> fetch_valid=1 from 2nd edge after release; instruction_fetch = 0x00000, 0x00001, 0x00002, … with pc_mux_output matching.
- stall=1 for 5 cycles while head = pc 3 -> outputs hold 0x00003 for all 5 cycles. After release the sequence is 4, 5, 6 with no gap or repeat; occupancy ≤ 2 throughout.
- select_pc_mux=1, branch_address=0x0040 while head = pc 7 -> 2 cycles of fetch_valid=0 and NOP_INSTR, then 0x00040, 0x00041. Stale pc 8/9 never appear.
- stall=1 and select_pc_mux=1 (branch_address=0x0010) in the same cycle -> redirect wins; next valid instruction is 0x00010.
- Start with RESET_PC=0xFFFE -> sequence pc 0xFFFE, 0xFFFF, 0x0000.
- reset=0 asserted for 1 cycle mid-stall with buffer full -> next edge fetch_valid=0 and instruction_fetch=0. The first instruction after release is pc 0; with FETCH_PERF_COUNTERS_EN, counters read 0.
